// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with registered, active-low anode/cathode outputs.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dig4,
  output logic [3:0] an,
  output logic [6:0] ca,
  output logic       frame_tick
);

  localparam int          CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(REFRESH_DIV - 1);
  localparam logic [31:0] GUARD_U = GUARD_CYCLES;

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    shadow_reg [4];
  logic [3:0]    dig_in [4];
  logic [3:0]    an_reg;
  logic [6:0]    ca_reg;
  logic          wrap_reg;
  logic          frame_tick_reg;

  logic [3:0]    cur_digit;
  logic          guard_on;
  logic          blank_on;
  logic [3:0]    an_next;
  logic [6:0]    ca_next;

  assign dig_in[0] = dig1;
  assign dig_in[1] = dig2;
  assign dig_in[2] = dig3;
  assign dig_in[3] = dig4;

  // Shadow digits: clr has priority over load.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (clr) begin
          shadow_reg[gi] <= 4'd0;
        end else if (load) begin
          shadow_reg[gi] <= dig_in[gi];
        end
      end
    end
  endgenerate

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    cur_digit = shadow_reg[idx_reg];
    guard_on  = (32'(cnt_reg) < GUARD_U);
    blank_on  = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    // A slot blanks only when it and every more-significant digit are zero.
    case (idx_reg)
      2'd0: blank_on = (shadow_reg[0] == 4'd0);
      2'd1: blank_on = (shadow_reg[0] == 4'd0) && (shadow_reg[1] == 4'd0);
      2'd2: blank_on = (shadow_reg[0] == 4'd0) && (shadow_reg[1] == 4'd0) &&
                       (shadow_reg[2] == 4'd0);
      default: blank_on = 1'b0;
    endcase
`endif
    an_next = 4'b1111;
    ca_next = 7'b1111111;
    if (!guard_on && !blank_on) begin
      an_next = ~(4'b1000 >> idx_reg);
      ca_next = hex_to_seg(cur_digit);
    end
  end

  // wrap_reg marks that idx just rolled 3->0, so the following output cycle is the first of a new frame.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg        <= '0;
      idx_reg        <= 2'd0;
      an_reg         <= 4'b1111;
      ca_reg         <= 7'b1111111;
      wrap_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      ca_reg         <= ca_next;
      frame_tick_reg <= wrap_reg;
      if (cnt_reg == CNT_TOP) begin
        cnt_reg  <= '0;
        idx_reg  <= idx_reg + 2'd1;
        wrap_reg <= (idx_reg == 2'd3);
      end else begin
        cnt_reg  <= cnt_reg + CW'(1);
        wrap_reg <= 1'b0;
      end
    end
  end

  assign an         = an_reg;
  assign ca         = ca_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, GUARD_CYCLES=1.
// Blanking expectations follow SEG_LZ_BLANK_EN when the bench is built with it.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       clr;
  logic       load;
  logic [3:0] dig1, dig2, dig3, dig4;
  logic [3:0] an;
  logic [6:0] ca;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.REFRESH_DIV(4), .GUARD_CYCLES(1)) dut (
    .clk(clk), .clr(clr), .load(load),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .an(an), .ca(ca), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Runs one 16-cycle frame starting at the output cycle for (idx 0, cnt 0).
  task automatic run_frame(input logic do_load, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input logic ft_first);
    logic [3:0] dv [4];
    logic [3:0] an_tab [4];
    logic       blank;
    logic [3:0] exp_an;
    logic [6:0] exp_ca;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    an_tab[0] = 4'b0111; an_tab[1] = 4'b1011; an_tab[2] = 4'b1101; an_tab[3] = 4'b1110;
    if (do_load) begin
      load = 1'b1; dig1 = a; dig2 = b; dig3 = c; dig4 = d;
    end
    for (int k = 0; k < 16; k++) begin
      int ix;
      int cn;
      tick();
      load = 1'b0; dig1 = 4'h9; dig2 = 4'h9; dig3 = 4'h9; dig4 = 4'h9;
      ix = k / 4;
      cn = k % 4;
      blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      if (ix == 0) blank = (dv[0] == 0);
      if (ix == 1) blank = (dv[0] == 0) && (dv[1] == 0);
      if (ix == 2) blank = (dv[0] == 0) && (dv[1] == 0) && (dv[2] == 0);
`endif
      if (cn < 1 || blank) begin
        exp_an = 4'b1111; exp_ca = 7'b1111111;
      end else begin
        exp_an = an_tab[ix]; exp_ca = seg_of(dv[ix]);
      end
      $display("frame k=%0d an=%b ca=%b ft=%b", k, an, ca, frame_tick);
      check_val("frame_an", 32'(an), 32'(exp_an));
      check_val("frame_ca", 32'(ca), 32'(exp_ca));
      check_val("frame_ft", 32'(frame_tick), 32'((k == 0) && ft_first));
    end
  endtask

  initial begin
    clr = 1'b1; load = 1'b0;
    dig1 = 4'h0; dig2 = 4'h0; dig3 = 4'h0; dig4 = 4'h0;

    for (int i = 0; i < 3; i++) begin
      tick();
      $display("reset cycle %0d an=%b ca=%b ft=%b", i, an, ca, frame_tick);
      check_val("rst_an", 32'(an), 32'hF);
      check_val("rst_ca", 32'(ca), 32'h7F);
      check_val("rst_ft", 32'(frame_tick), 32'h0);
    end
    clr = 1'b0;

    run_frame(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    run_frame(1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    run_frame(1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    run_frame(1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    run_frame(1'b1, 4'hA, 4'hB, 4'hE, 4'hF, 1'b1);
    run_frame(1'b1, 4'h0, 4'h0, 4'h4, 4'h2, 1'b1);
    run_frame(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    // Mid-slot load inside the idx 3 slot.
    for (int i = 0; i < 14; i++) tick();
    check_val("mid_pre_an", 32'(an), 32'hE);
    check_val("mid_pre_ca", 32'(ca), 32'h01);
    load = 1'b1; dig4 = 4'h8;
    tick();
    load = 1'b0; dig4 = 4'h9;
    $display("midload capture an=%b ca=%b", an, ca);
    check_val("mid_old_ca", 32'(ca), 32'h01);
    tick();
    $display("midload next an=%b ca=%b", an, ca);
    check_val("mid_new_an", 32'(an), 32'hE);
    check_val("mid_new_ca", 32'(ca), 32'h00);
    tick();
    check_val("mid_wrap_ft", 32'(frame_tick), 32'h1);

    // clr and load together: clr wins.
    clr = 1'b1; load = 1'b1;
    dig1 = 4'h8; dig2 = 4'h8; dig3 = 4'h8; dig4 = 4'h8;
    tick();
    $display("collision an=%b ca=%b ft=%b", an, ca, frame_tick);
    check_val("coll_an", 32'(an), 32'hF);
    check_val("coll_ca", 32'(ca), 32'h7F);
    check_val("coll_ft", 32'(frame_tick), 32'h0);
    clr = 1'b0; load = 1'b0;
    dig1 = 4'h9; dig2 = 4'h9; dig3 = 4'h9; dig4 = 4'h9;
    run_frame(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // clr at cnt=2 of idx 2.
    run_frame(1'b1, 4'h5, 4'h6, 4'h7, 4'h8, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check_val("pre_clr_an", 32'(an), 32'hD);
    clr = 1'b1;
    tick();
    $display("midslot clr an=%b ca=%b", an, ca);
    check_val("mclr_an", 32'(an), 32'hF);
    check_val("mclr_ca", 32'(ca), 32'h7F);
    clr = 1'b0;
    run_frame(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL provide parameter REFRESH_DIV, default 100000, giving the clock cycles per digit slot (1 ms at 100 MHz); legal range is 2 or more.
REQ-002 The block SHALL provide parameter GUARD_CYCLES, default 1000, giving the anode-off cycles at the start of each slot; legal range is 0 to REFRESH_DIV-1.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  single-cycle strobe that captures dig1..dig4 into shadow registers.
REQ-006 dig1, dig2, dig3, dig4  input  4 each  BCD/hex digits; dig1 is the leftmost, most-significant digit.
REQ-007 an  output  4  anodes, active-low; an[3] drives dig1 and an[0] drives dig4.
REQ-008 ca  output  7  cathodes, active-low; ca[6]=a through ca[0]=g.
REQ-009 frame_tick  output  1  one-cycle pulse when the slot index wraps from 3 to 0.

Function
REQ-010 The prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap; when cnt==REFRESH_DIV-1, slot index idx SHALL advance 0->1->2->3->0.
REQ-011 The idx-to-digit mapping SHALL be: idx 0=dig1/an 0111, idx 1=dig2/an 1011, idx 2=dig3/an 1101, idx 3=dig4/an 1110.
REQ-012 an and ca SHALL be registered and SHALL reflect the (cnt, idx, shadow) state of the previous cycle, giving 1-cycle latency.
REQ-013 an SHALL be 1111 while cnt<GUARD_CYCLES (ghost guard); otherwise exactly one anode SHALL be low; GUARD_CYCLES=0 means no guard.
REQ-014 ca SHALL decode as active-low hex: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-015 During the guard interval or a blanked slot, ca SHALL be 1111111.
REQ-016 When load=1, shadows SHALL capture dig1..dig4 on that edge, and the next registered output SHALL use the new values, even mid-slot.
REQ-017 Inputs dig1..dig4 SHALL be ignored while load=0.
REQ-018 frame_tick SHALL be 1 for exactly the one cycle in which the registered outputs first present idx 0 after idx 3, and SHALL be 0 otherwise.
REQ-019 When clr and load are both 1 on the same edge, clr SHALL win and the shadows SHALL clear.

Reset
REQ-020 With clr=1 at an edge, the block SHALL set cnt=0, idx=0, all shadows=0, an=1111, ca=1111111 and frame_tick=0.
REQ-021 A clr asserted mid-slot SHALL abort the slot; the first cycle after clr deasserts SHALL start slot 0 at cnt=0.
REQ-022 frame_tick SHALL NOT pulse on reset exit.

Configuration
REQ-023 Macro SEG_LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-024 With SEG_LZ_BLANK_EN defined, a slot for dig1, dig2 or dig3 SHALL be fully blanked (an=1111, ca=1111111) when that digit and every more-significant shadow digit are 0; dig4 SHALL never be blanked.
REQ-025 With SEG_LZ_BLANK_EN undefined, all four digits SHALL always be displayed, including zeros.

Verification (REFRESH_DIV=4, GUARD_CYCLES=1)
REQ-026 The bench SHALL check reset: hold clr 3 cycles -> an=1111, ca=1111111, frame_tick=0; after release, an=0111 from the 2nd cycle for 3 cycles, then 1011.
REQ-027 The bench SHALL check load and decode: load dig=1,2,3,4 -> over one frame ca sequence 1001111, 0010010, 0000110, 1001100 on an 0111, 1011, 1101, 1110, with 1111 for 1 cycle before each.
REQ-028 The bench SHALL check frame_tick: run 3 frames -> frame_tick pulses every 16 cycles, coincident with the first output cycle of idx 0.
REQ-029 The bench SHALL check blanking with SEG_LZ_BLANK_EN defined: load 0,0,4,2 -> slots 0-1 an=1111; slot 2 shows 4; slot 3 shows 2; load 0,0,0,0 -> only dig4 shows 0000001.
REQ-030 The bench SHALL check clr/load collision and mid-slot reset: clr and load asserted together with dig=8,8,8,8 -> shadows 0; clr at cnt=2 of idx 2 -> restart at idx 0, cnt 0.
REQ-031 The bench SHALL check hex and mid-slot load: load A,b,E,F -> codes 0001000, 1100000, 0110000, 0111000; a load during the idx 3 slot changes ca on the next cycle.
